// File: rtl/sync1001_tx_if.sv
// sync1001_tx_if: payload handshake and serial line bundle for sync1001_tx
interface sync1001_tx_if #(parameter int DATA_W = 8);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              tx_out;
  logic              tx_active;
  logic              frame_done;
  modport master (output in_valid, in_data, input in_ready, tx_out, tx_active, frame_done);
  modport slave (input in_valid, in_data, output in_ready, tx_out, tx_active, frame_done);
endinterface

// File: rtl/sync1001_tx.sv
// sync1001_tx: serialises a payload as 1001 sync, data MSB first, even parity, idle gap
module sync1001_tx #(
  parameter int DATA_W   = 8,
  parameter int GAP_BITS = 2
) (
  input logic          clk,
  input logic          rst,
  sync1001_tx_if.slave bus
);
  localparam int M1 = DATA_W > 4 ? DATA_W : 4;
  localparam int MX = GAP_BITS > M1 ? GAP_BITS : M1;
  localparam int CW = $clog2(MX) + 1;
  localparam logic [CW-1:0] SYNC_LAST = CW'(3);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_BITS - 1);
  typedef enum logic [2:0] {IDLE, SYNC, DATA, PAR, GAP} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d, sh;
  // state, bit counter and captured payload registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end
  // next state: the payload is captured only in IDLE, so busy-time input changes are inert
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.in_valid) begin
          state_d = SYNC;
          data_d  = bus.in_data;
        end
      end
      SYNC: if (cnt_q == SYNC_LAST) begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: if (cnt_q == DATA_LAST) begin
        state_d = PAR;
        cnt_d   = '0;
      end
      PAR: begin
        state_d = GAP;
        cnt_d   = '0;
      end
      GAP: if (cnt_q == GAP_LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  // outputs decoded from registered state only; payload is indexed, not shifted, so parity stays available
  always_comb begin
    sh             = data_q << cnt_q;
    bus.in_ready   = state_q == IDLE;
    bus.tx_active  = state_q == SYNC || state_q == DATA || state_q == PAR;
    bus.frame_done = state_q == GAP && cnt_q == GAP_LAST;
    bus.tx_out     = state_q == SYNC ? (cnt_q == '0 || cnt_q == SYNC_LAST) :
                     state_q == DATA ? sh[DATA_W-1] :
                     state_q == PAR  ? ^data_q : 1'b0;
  end
endmodule

// File: tb/tb_sync1001_tx.sv
// tb_sync1001_tx: directed table-driven checks of sync1001_tx framing
module tb_sync1001_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  always #5 clk = ~clk;
  sync1001_tx_if #(.DATA_W(8))  m ();
  sync1001_tx_if #(.DATA_W(1))  s1 ();
  sync1001_tx_if #(.DATA_W(32)) s2 ();
  sync1001_tx #(.DATA_W(8),  .GAP_BITS(2))  dut  (.clk(clk), .rst(rst), .bus(m));
  sync1001_tx #(.DATA_W(1),  .GAP_BITS(1))  dut1 (.clk(clk), .rst(rst), .bus(s1));
  sync1001_tx #(.DATA_W(32), .GAP_BITS(15)) dut2 (.clk(clk), .rst(rst), .bus(s2));
  typedef struct {
    logic [7:0]  d;
    logic [14:0] exp;
  } vec_t;
  vec_t tbl[5];
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", n, got, exp);
    else passed++;
  endtask
  // called at a negedge with the DUT idle; returns at the negedge of the first idle cycle after the frame
  task automatic frame(input logic [7:0] d, input logic [14:0] exp, input bit keep, input bit rnd,
                       input logic [7:0] nd, input string n);
    m.in_valid = 1'b1;
    m.in_data  = d;
    chk({n, ":ready"}, 32'(m.in_ready), 32'd1);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      m.in_valid = keep;
      m.in_data  = rnd ? 8'($urandom) : nd;
      chk($sformatf("%s:c%0d", n, k), 32'({m.tx_out, m.tx_active, m.frame_done}),
          32'({exp[15-k], k <= 13, k == 15}));
    end
    @(negedge clk);
    chk({n, ":idle"}, 32'({m.in_ready, m.tx_out, m.tx_active, m.frame_done}), 32'b1000);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [31:0] dw;
    logic [6:0]  e1;
    logic [3:0]  e4;
    logic        eb;
    tbl[0] = '{8'hA5, 15'b1001_10100101_0_00};
    tbl[1] = '{8'h01, 15'b1001_00000001_1_00};
    tbl[2] = '{8'hFF, 15'b1001_11111111_0_00};
    tbl[3] = '{8'h00, 15'b1001_00000000_0_00};
    tbl[4] = '{8'h3C, 15'b1001_00111100_0_00};
    m.in_valid = 1'b0;  m.in_data = '0;
    s1.in_valid = 1'b0; s1.in_data = '0;
    s2.in_valid = 1'b0; s2.in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", 32'({m.in_ready, m.tx_out, m.tx_active, m.frame_done}), 32'b1000);
    m.in_valid = 1'b1;
    m.in_data  = 8'hFF;
    @(negedge clk);
    chk("reset_prio", 32'({m.in_ready, m.tx_out, m.tx_active, m.frame_done}), 32'b1000);
    m.in_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) frame(tbl[i].d, tbl[i].exp, 1'b0, 1'b0, 8'h00, $sformatf("vec%0d", i));
    frame(8'h3C, 15'b1001_00111100_0_00, 1'b1, 1'b0, 8'hC3, "b2b0");
    frame(8'hC3, 15'b1001_11000011_0_00, 1'b0, 1'b0, 8'h00, "b2b1");
    frame(8'h5A, 15'b1001_01011010_0_00, 1'b1, 1'b1, 8'h00, "busy");
    m.in_valid = 1'b0;
    @(negedge clk);
    chk("busy_noextra", 32'({m.in_ready, m.tx_active}), 32'b10);
    m.in_valid = 1'b1;
    m.in_data  = 8'hA5;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      m.in_valid = 1'b0;
    end
    chk("mid_data3", 32'({m.tx_out, m.tx_active, m.frame_done}), 32'b110);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst", 32'({m.in_ready, m.tx_out, m.tx_active, m.frame_done}), 32'b1000);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d", k), 32'({m.in_ready, m.tx_active, m.frame_done}), 32'b100);
    end
    frame(8'h81, 15'b1001_10000001_0_00, 1'b0, 1'b0, 8'h00, "after_rst");
    e1 = 7'b1001_1_1_0;
    s1.in_valid = 1'b1;
    s1.in_data  = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      e4 = k == 8 ? 4'b0001 : k == 9 ? 4'b1100 : {e1[7-k], 1'(k <= 6), 1'(k == 7), 1'b0};
      chk($sformatf("w1:c%0d", k), 32'({s1.tx_out, s1.tx_active, s1.frame_done, s1.in_ready}), 32'(e4));
    end
    s1.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("w1:drain", 32'({s1.in_ready, s1.tx_active}), 32'b10);
    dw = 32'hDEADBEEF;
    e4 = 4'b1001;
    s2.in_valid = 1'b1;
    s2.in_data  = dw;
    for (int k = 1; k <= 53; k++) begin
      @(negedge clk);
      s2.in_valid = 1'b0;
      eb = k <= 4 ? e4[4-k] : k <= 36 ? dw[36-k] : 1'b0;
      chk($sformatf("w32:c%0d", k), 32'({s2.tx_out, s2.tx_active, s2.frame_done, s2.in_ready}),
          32'({eb, 1'(k <= 37), 1'(k == 52), 1'(k == 53)}));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
